// File: rtl/hweval_mont_sequencer.sv
// Drives an external Montgomery multiplier through N_ITER dependent multiplications,
// folding each result into a signature while counting busy cycles and watchdogging each wait.
module hweval_mont_sequencer #(
  parameter int WIDTH   = 1024,
  parameter int N_ITER  = 256,
  parameter int SIG_W   = 32,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            go,
  input  logic [WIDTH-1:0]                seed_a,
  input  logic [WIDTH-1:0]                seed_b,
  input  logic [WIDTH-1:0]                mod_in,
  output logic                            mont_start,
  output logic [WIDTH-1:0]                mont_a,
  output logic [WIDTH-1:0]                mont_b,
  output logic [WIDTH-1:0]                mont_m,
  input  logic                            mont_done,
  input  logic [WIDTH-1:0]                mont_result,
  output logic                            busy,
  output logic                            run_done,
  output logic                            timeout_err,
  output logic [$clog2(N_ITER+1)-1:0]     iter_cnt,
  output logic [CNT_W-1:0]                cycle_cnt,
  output logic [SIG_W-1:0]                signature,
  output logic                            data_ok
);

  localparam int IW  = $clog2(N_ITER+1);
  localparam int WDW = $clog2(TIMEOUT+1);
  localparam logic [IW-1:0]    LAST_ITER = IW'(N_ITER-1);
  localparam logic [WDW-1:0]   WD_LAST   = WDW'(TIMEOUT-1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT, S_UPDATE, S_DONE, S_ERROR
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] r;
  logic [WDW-1:0]   wdog;

  // Handshake: mont_start is a one-cycle request issued in LOAD; mont_done qualifies
  // mont_result and is honoured only in WAIT, where it wins over a same-cycle timeout.
  assign mont_start  = (state == S_LOAD);
  assign busy        = (state == S_LOAD) || (state == S_WAIT) || (state == S_UPDATE);
  assign run_done    = (state == S_DONE);
  assign timeout_err = (state == S_ERROR);
  assign data_ok     = run_done & mont_b[WIDTH-1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      mont_a    <= '0;
      mont_b    <= '0;
      mont_m    <= '0;
      r         <= '0;
      wdog      <= '0;
      iter_cnt  <= '0;
      cycle_cnt <= '0;
      signature <= '0;
    end else begin
      if (busy && (cycle_cnt != CNT_MAX)) cycle_cnt <= cycle_cnt + 1'b1;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (go) begin
            mont_a    <= seed_a;
            mont_b    <= seed_b;
            mont_m    <= mod_in;
            iter_cnt  <= '0;
            cycle_cnt <= '0;
            signature <= '0;
            wdog      <= '0;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          wdog  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (mont_done) begin
            r     <= mont_result;
            state <= S_UPDATE;
          end else begin
            wdog <= wdog + 1'b1;
            if (wdog == WD_LAST) state <= S_ERROR;
          end
        end
        S_UPDATE: begin
          // Feed the result back: next a mixes old b with r, next b is r itself.
          mont_a    <= mont_b ^ r;
          mont_b    <= r;
          signature <= {signature[SIG_W-2:0], signature[SIG_W-1]} ^ r[SIG_W-1:0];
          iter_cnt  <= iter_cnt + 1'b1;
          state     <= (iter_cnt == LAST_ITER) ? S_DONE : S_LOAD;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hweval_mont_sequencer.sv
// Bench for hweval_mont_sequencer: a run-level arithmetic model predicts every output each
// cycle for two instances (32-bit and 4-bit cycle counters) driven by an add-stub multiplier.
module tb_hweval_mont_sequencer;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn, go;
  logic [W-1:0]  seed_a, seed_b, mod_in;
  logic          mont_done;
  logic [W-1:0]  mont_result;

  logic          s0_start, s0_busy, s0_rdone, s0_err, s0_dok;
  logic [W-1:0]  s0_a, s0_b, s0_m, s0_sig;
  logic [2:0]    s0_iter;
  logic [31:0]   s0_cyc;

  logic          s1_start, s1_busy, s1_rdone, s1_err, s1_dok;
  logic [W-1:0]  s1_a, s1_b, s1_m, s1_sig;
  logic [2:0]    s1_iter;
  logic [3:0]    s1_cyc;

  hweval_mont_sequencer #(.WIDTH(W), .N_ITER(N), .SIG_W(W), .CNT_W(32), .TIMEOUT(TO)) u0 (
    .clk(clk), .resetn(resetn), .go(go), .seed_a(seed_a), .seed_b(seed_b), .mod_in(mod_in),
    .mont_start(s0_start), .mont_a(s0_a), .mont_b(s0_b), .mont_m(s0_m),
    .mont_done(mont_done), .mont_result(mont_result),
    .busy(s0_busy), .run_done(s0_rdone), .timeout_err(s0_err), .iter_cnt(s0_iter),
    .cycle_cnt(s0_cyc), .signature(s0_sig), .data_ok(s0_dok)
  );

  hweval_mont_sequencer #(.WIDTH(W), .N_ITER(N), .SIG_W(W), .CNT_W(4), .TIMEOUT(TO)) u1 (
    .clk(clk), .resetn(resetn), .go(go), .seed_a(seed_a), .seed_b(seed_b), .mod_in(mod_in),
    .mont_start(s1_start), .mont_a(s1_a), .mont_b(s1_b), .mont_m(s1_m),
    .mont_done(mont_done), .mont_result(mont_result),
    .busy(s1_busy), .run_done(s1_rdone), .timeout_err(s1_err), .iter_cnt(s1_iter),
    .cycle_cnt(s1_cyc), .signature(s1_sig), .data_ok(s1_dok)
  );

  // Stub multiplier: result = a+b, done in WAIT cycle cfg_L, optional spurious done in LOAD.
  int stub_cnt;
  int cfg_L;
  bit cfg_never, cfg_ld;

  always @(posedge clk or negedge resetn) begin
    if (!resetn)                                stub_cnt <= 0;
    else if (s0_start)                          stub_cnt <= 1;
    else if (mont_done)                         stub_cnt <= 0;
    else if (stub_cnt != 0 && stub_cnt < 1000)  stub_cnt <= stub_cnt + 1;
  end

  assign mont_done   = (cfg_ld && s0_start) || (!cfg_never && (stub_cnt == cfg_L));
  assign mont_result = s0_a + s0_b;

  // Run-level model: per-iteration operands/signature precomputed at go, outputs indexed by
  // the cycle offset since go was accepted.
  bit           m_run, m_never;
  int           m_o, m_L, m_end;
  logic [W-1:0] ea [0:N];
  logic [W-1:0] eb [0:N];
  logic [W-1:0] esig [0:N];
  logic [W-1:0] m_mod;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;

  function automatic bit m_accept();
    return !m_run || (m_o >= m_end);
  endfunction

  task automatic model_reset();
    m_run = 0; m_never = 0; m_o = 0; m_L = 1; m_end = 0; m_mod = '0;
    for (int k = 0; k <= N; k++) begin ea[k] = '0; eb[k] = '0; esig[k] = '0; end
  endtask

  task automatic model_start(input logic [W-1:0] a, b, m, input int L, input bit never);
    logic [W-1:0] r;
    ea[0] = a; eb[0] = b; esig[0] = '0;
    for (int k = 0; k < N; k++) begin
      r         = ea[k] + eb[k];
      ea[k+1]   = eb[k] ^ r;
      eb[k+1]   = r;
      esig[k+1] = {esig[k][W-2:0], esig[k][W-1]} ^ r;
    end
    m_mod = m; m_L = L; m_never = never; m_run = 1; m_o = 0;
    m_end = never ? (1 + TO) : N * (L + 2);
  endtask

  task automatic model_update();
    if (!resetn)                  model_reset();
    else if (go && m_accept())    model_start(seed_a, seed_b, mod_in, cfg_L, cfg_never);
    else if (m_run && m_o < m_end) m_o++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input string tag, input logic start, busy, rd, err, dok,
                           input logic [W-1:0] a, b, m, sig, input logic [2:0] iter,
                           input logic [31:0] cyc, input logic [31:0] capv);
    int k;
    bit e_busy, e_start, e_done, e_err;
    logic [31:0] e_cyc;
    k = 0; e_busy = 0; e_start = 0; e_done = 0; e_err = 0; e_cyc = '0;
    if (m_run) begin
      if (m_o < m_end) begin
        e_busy = 1;
        e_cyc  = 32'(m_o);
        if (m_never) e_start = (m_o == 0);
        else begin
          k       = m_o / (m_L + 2);
          e_start = ((m_o % (m_L + 2)) == 0);
        end
      end else begin
        e_cyc = 32'(m_end);
        if (m_never) e_err = 1;
        else begin e_done = 1; k = N; end
      end
    end
    if (e_cyc > capv) e_cyc = capv;
    chk({tag, "_start"}, 32'(start), 32'(e_start));
    chk({tag, "_busy"},  32'(busy),  32'(e_busy));
    chk({tag, "_rdone"}, 32'(rd),    32'(e_done));
    chk({tag, "_err"},   32'(err),   32'(e_err));
    chk({tag, "_a"},     32'(a),     32'(ea[k]));
    chk({tag, "_b"},     32'(b),     32'(eb[k]));
    chk({tag, "_m"},     32'(m),     32'(m_mod));
    chk({tag, "_sig"},   32'(sig),   32'(esig[k]));
    chk({tag, "_iter"},  32'(iter),  32'(k));
    chk({tag, "_cyc"},   cyc,        e_cyc);
    chk({tag, "_dok"},   32'(dok),   32'(e_done && eb[k][W-1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    if (s0_start) pulses++;
    check_dut("u0", s0_start, s0_busy, s0_rdone, s0_err, s0_dok, s0_a, s0_b, s0_m, s0_sig,
              s0_iter, s0_cyc, 32'hFFFF_FFFF);
    check_dut("u1", s1_start, s1_busy, s1_rdone, s1_err, s1_dok, s1_a, s1_b, s1_m, s1_sig,
              s1_iter, {28'd0, s1_cyc}, 32'd15);
  endtask

  task automatic async_reset();
    #2;
    resetn = 1'b0;
    #1;
    chk("async_start", 32'(s0_start), 32'd0);
    chk("async_busy",  32'(s0_busy),  32'd0);
    chk("async_a",     32'(s0_a),     32'd0);
    chk("async_b",     32'(s0_b),     32'd0);
    chk("async_m",     32'(s0_m),     32'd0);
    chk("async_iter",  32'(s0_iter),  32'd0);
    chk("async_cyc",   s0_cyc,        32'd0);
    chk("async_sig",   32'(s0_sig),   32'd0);
    chk("async_u1cyc", 32'(s1_cyc),   32'd0);
    model_reset();
    go = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic run_seq(input logic [W-1:0] a, b, m, input int L, input bit never, ld,
                         spam, input int rst_at);
    bit finished;
    seed_a = a; seed_b = b; mod_in = m;
    cfg_L = L; cfg_never = never; cfg_ld = ld;
    go = 1'b1;
    tick();
    go = 1'b0;
    finished = 0;
    for (int i = 0; i < 200; i++) begin
      if (m_accept()) begin finished = 1; break; end
      if (rst_at >= 0 && m_o == rst_at) begin async_reset(); finished = 1; break; end
      go = spam ? ($urandom_range(0, 1) == 1) : 1'b0;
      if (spam) begin
        seed_a = W'($urandom); seed_b = W'($urandom); mod_in = W'($urandom);
      end
      tick();
    end
    go = 1'b0;
    if (!finished) begin
      n_fail++;
      $display("FAIL run_budget: run did not finish within 200 cycles at %0t", $time);
    end
  endtask

  task automatic check_s1_final();
    chk("s1_a",     32'(s0_a),     32'd25);
    chk("s1_b",     32'(s0_b),     32'd21);
    chk("s1_m",     32'(s0_m),     32'hBEEF);
    chk("s1_sig",   32'(s0_sig),   32'd9);
    chk("s1_iter",  32'(s0_iter),  32'd4);
    chk("s1_cyc",   s0_cyc,        32'd20);
    chk("s1_rdone", 32'(s0_rdone), 32'd1);
    chk("s1_err",   32'(s0_err),   32'd0);
    chk("s1_dok",   32'(s0_dok),   32'd0);
    chk("s6_cyc",   32'(s1_cyc),   32'd15);
    chk("s6_rdone", 32'(s1_rdone), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish at %0t", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    int p0;
    resetn = 1'b0; go = 1'b0; seed_a = '0; seed_b = '0; mod_in = '0;
    cfg_L = 3; cfg_never = 0; cfg_ld = 0;
    model_reset();
    @(negedge clk);
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // Scenario 1: basic chain from seeds 1,1.
    run_seq(16'd1, 16'd1, 16'hBEEF, 3, 0, 0, 0, -1);
    chk("model_a4",   32'(ea[4]),   32'd25);
    chk("model_b4",   32'(eb[4]),   32'd21);
    chk("model_sig4", 32'(esig[4]), 32'd9);
    check_s1_final();

    // Scenario 2: no done -> timeout, then recovery.
    p0 = pulses;
    run_seq(16'd1, 16'd1, 16'hBEEF, 3, 1, 0, 0, -1);
    chk("s2_err",    32'(s0_err),  32'd1);
    chk("s2_iter",   32'(s0_iter), 32'd0);
    chk("s2_busy",   32'(s0_busy), 32'd0);
    chk("s2_cyc",    s0_cyc,       32'd9);
    chk("s2_pulses", 32'(pulses - p0), 32'd1);
    repeat (2) tick();
    run_seq(16'd1, 16'd1, 16'hBEEF, 3, 0, 0, 0, -1);
    check_s1_final();

    // Scenario 3: go spam while busy.
    p0 = pulses;
    run_seq(16'd1, 16'd1, 16'hBEEF, 3, 0, 0, 1, -1);
    seed_a = 16'h1234; seed_b = 16'h5678; mod_in = 16'h9ABC;
    check_s1_final();
    chk("s3_pulses", 32'(pulses - p0), 32'd4);

    // Scenario 4: reset in the 2nd WAIT cycle of the 2nd iteration, then rerun.
    run_seq(16'd1, 16'd1, 16'hBEEF, 3, 0, 0, 0, 7);
    tick();
    run_seq(16'd1, 16'd1, 16'hBEEF, 3, 0, 0, 0, -1);
    check_s1_final();

    // Scenario 5: spurious done in LOAD, real done on the last watchdog cycle.
    run_seq(16'd1, 16'd1, 16'hBEEF, TO, 0, 1, 0, -1);
    chk("s5_err",   32'(s0_err),   32'd0);
    chk("s5_rdone", 32'(s0_rdone), 32'd1);
    chk("s5_a",     32'(s0_a),     32'd25);
    chk("s5_sig",   32'(s0_sig),   32'd9);
    chk("s5_cyc",   s0_cyc,        32'd40);
    chk("s5_u1cyc", 32'(s1_cyc),   32'd15);

    // Randomized runs.
    for (int n = 0; n < 30; n++) begin
      int  lat, rst;
      bit  nev, ld, sp;
      nev = ($urandom_range(0, 5) == 0);
      lat = $urandom_range(1, TO);
      ld  = ($urandom_range(0, 1) == 1);
      sp  = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : -1;
      run_seq(W'($urandom), W'($urandom), W'($urandom), lat, nev, ld, sp, rst);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hweval_mont_sequencer.md
Name: hweval_mont_sequencer

Overview:
Parametrised hardware-evaluation sequencer for the Montgomery multiplier cores. It runs a run-time-triggered chain of N_ITER dependent multiplications, feeding each result back as the next operands (a <= b ^ r, b <= r). It folds every result into a signature, counts cycles for throughput measurement, and guards each multiplication with a watchdog. The multiplier is external: this block drives its start/operand ports and consumes done/result.

Parameters:
WIDTH, 1024, operand/modulus/result width in bits
N_ITER, 256, multiplications per run (>=1)
SIG_W, 32, signature width (2 <= SIG_W <= WIDTH)
CNT_W, 32, cycle-counter width
TIMEOUT, 4096, max WAIT cycles per multiplication before abort (>=1)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
go  in  1  start-run pulse; sampled only in IDLE, DONE, ERROR
seed_a  in  WIDTH  initial operand a, latched on accepted go
seed_b  in  WIDTH  initial operand b, latched on accepted go
mod_in  in  WIDTH  modulus, latched on accepted go
mont_start  out  1  one-cycle start pulse to multiplier
mont_a  out  WIDTH  registered operand a
mont_b  out  WIDTH  registered operand b
mont_m  out  WIDTH  registered modulus
mont_done  in  1  multiplier completion, qualifies mont_result
mont_result  in  WIDTH  multiplier result
busy  out  1  high in LOAD/WAIT/UPDATE
run_done  out  1  high in DONE
timeout_err  out  1  high in ERROR
iter_cnt  out  $clog2(N_ITER+1)  completed multiplications this run
cycle_cnt  out  CNT_W  cycles spent in LOAD/WAIT/UPDATE this run, saturating
signature  out  SIG_W  folded result signature
data_ok  out  1  run_done & mont_b[WIDTH-1] (keeps the datapath from being optimised out)

Behaviour:
- Reset (async, resetn=0): state IDLE. All outputs and internal registers are 0, including mont_start. Reset mid-run aborts immediately; no further pulse is issued.
- States: IDLE, LOAD, WAIT, UPDATE, DONE, ERROR.
- IDLE/DONE/ERROR + go=1 -> LOAD: latch seed_a/seed_b/mod_in into mont_a/mont_b/mont_m; clear iter_cnt, cycle_cnt, signature, watchdog.
- go while busy is ignored.
- LOAD: mont_start=1 for exactly this cycle -> WAIT. Clear watchdog. Any mont_done seen in LOAD is ignored.
- WAIT: mont_start=0.
  - mont_done=1 -> UPDATE, capturing mont_result into an internal register r.
  - Otherwise watchdog++; when the watchdog reaches TIMEOUT -> ERROR.
  - If mont_done arrives in the same cycle the watchdog reaches TIMEOUT, done wins.
- UPDATE:
  - mont_a <= mont_b ^ r; mont_b <= r.
  - signature <= {signature[SIG_W-2:0], signature[SIG_W-1]} ^ r[SIG_W-1:0].
  - iter_cnt++.
  - If iter_cnt was N_ITER-1 -> DONE, else -> LOAD.
- DONE: run_done=1 and all outputs hold until the next accepted go or reset.
- ERROR: timeout_err=1, sticky. iter_cnt/signature/cycle_cnt hold values at abort. Cleared only by accepted go or reset.
- cycle_cnt increments every cycle in LOAD/WAIT/UPDATE. It saturates at 2^CNT_W-1 and never wraps.
- Per-iteration latency: 1 (LOAD) + L (WAIT cycles including the done cycle) + 1 (UPDATE). A full run with constant L costs N_ITER*(L+2) cycles.
- mont_a/b/m change only in the go-accept cycle and in UPDATE, so they are stable while the multiplier runs.

Test Plan:
All scenarios use WIDTH=16, SIG_W=16, N_ITER=4, TIMEOUT=8, and a stub multiplier with result = a+b mod 2^16 and mont_done high in the 3rd cycle after mont_start.
1. go with seed_a=1, seed_b=1 -> results 2,5,12,21. Final mont_a=25, mont_b=21, signature=9, iter_cnt=4, cycle_cnt=20, run_done=1, data_ok=0.
2. Stub never asserts done -> timeout_err=1 after 8 WAIT cycles, iter_cnt=0, busy=0, exactly one mont_start pulse. A following go clears timeout_err and completes scenario 1 results.
3. Pulse go repeatedly during a run -> ignored. Results identical to scenario 1 and exactly 4 mont_start pulses.
4. Deassert resetn in the 2nd WAIT cycle of iteration 2 -> all outputs 0 asynchronously (before next clk edge). After release, a new go reproduces scenario 1.
5. Stub asserts done in the LOAD cycle and again on the 8th WAIT cycle -> the LOAD-cycle done is ignored, the WAIT done wins over timeout, and the run completes with no timeout_err.
6. CNT_W=4 with stub latency 3 -> cycle_cnt saturates at 15, no wrap, run_done=1.
